// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared types and default BCD limits for the RTC setting pages
// Shared by the field editor and its BCD stepper.
package rtc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int BCD_W = 8;

  localparam logic [23:0] TIME_MAX = 24'h23_59_59;
  // Date page order from MSB: year, month, date, weekday
  localparam logic [31:0] DATE_MAX = 32'h99_12_31_07;
  localparam logic [31:0] DATE_MIN = 32'h00_01_01_01;

  // True when v is two valid BCD digits inside [mn, mx]; valid BCD orders like binary
  function automatic logic bcd_ok(input logic [BCD_W-1:0] v,
                                  input logic [BCD_W-1:0] mn,
                                  input logic [BCD_W-1:0] mx);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= mn) && (v <= mx);
  endfunction

endpackage

// File: rtl/bcd_field_step.sv
// rtl/bcd_field_step.sv - combinational BCD +1/-1 of one field with limit wrap
// inc has priority over dec; with neither set the value passes through.
module bcd_field_step
  import rtc_pkg::*;
(
  input  logic [BCD_W-1:0] value,
  input  logic [BCD_W-1:0] min,
  input  logic [BCD_W-1:0] max,
  input  logic             inc,
  input  logic             dec,
  output logic [BCD_W-1:0] value_next
);

  always_comb begin
    value_next = value;
    if (inc) begin
      if (value == max)
        value_next = min;
      else if (value[3:0] >= 4'd9)
        value_next = {value[7:4] + 4'd1, 4'd0};
      else
        value_next = {value[7:4], value[3:0] + 4'd1};
    end else if (dec) begin
      if (value == min)
        value_next = max;
      else if (value[3:0] == 4'd0)
        value_next = {value[7:4] - 4'd1, 4'd9};
      else
        value_next = {value[7:4], value[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/rtc_field_editor.sv
// rtl/rtc_field_editor.sv - key-driven BCD time/date editor with blink and RTC commit
// One instance per display page; commits through a req/ack write to the DS1302 driver.
module rtc_field_editor
  import rtc_pkg::*;
#(
  parameter int                      NUM_FIELDS  = 3,
  parameter logic [8*NUM_FIELDS-1:0] FIELD_MAX   = TIME_MAX,
  parameter logic [8*NUM_FIELDS-1:0] FIELD_MIN   = '0,
  parameter int                      BLINK_DIV   = 12_500_000,
  parameter int                      TIMEOUT_CYC = 500_000_000,
  localparam int                     CW          = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_mode,
  input  logic                    key_next,
  input  logic                    key_inc,
  input  logic                    key_dec,
  input  logic [8*NUM_FIELDS-1:0] live_bcd,
  input  logic                    wr_ack,
  output logic [8*NUM_FIELDS-1:0] disp_bcd,
  output logic [NUM_FIELDS-1:0]   disp_blank,
  output logic                    wr_req,
  output logic [8*NUM_FIELDS-1:0] wr_data,
  output logic                    wr_ch,
  output logic                    editing,
  output logic [CW-1:0]           cursor
);

  localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYC - 1);

  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_lim
    if (FIELD_MIN[8*g +: 8] > FIELD_MAX[8*g +: 8]) begin : g_bad
      $error("rtc_field_editor: FIELD_MIN above FIELD_MAX in field %0d", g);
    end
  end

  state_t                  state;
  logic [8*NUM_FIELDS-1:0] edit_bcd;
  logic [8*NUM_FIELDS-1:0] snap;
  logic [8*NUM_FIELDS-1:0] stepped;
  logic [BCD_W-1:0]        step_out;
  logic [31:0]             blink_cnt;
  logic [31:0]             idle_cnt;
  logic                    phase;
  logic                    any_key;
  logic [NUM_FIELDS-1:0]   cur_mask;

  assign any_key  = key_mode | key_next | key_inc | key_dec;
  assign cur_mask = NUM_FIELDS'(1) << cursor;

  // Out-of-range or non-BCD live fields come in as their minimum
  always_comb begin
    snap = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      snap[8*i +: 8] = bcd_ok(live_bcd[8*i +: 8], FIELD_MIN[8*i +: 8], FIELD_MAX[8*i +: 8])
                       ? live_bcd[8*i +: 8] : FIELD_MIN[8*i +: 8];
    end
  end

  bcd_field_step u_step (
    .value      (edit_bcd[8*cursor +: 8]),
    .min        (FIELD_MIN[8*cursor +: 8]),
    .max        (FIELD_MAX[8*cursor +: 8]),
    .inc        (key_inc),
    .dec        (key_dec),
    .value_next (step_out)
  );

  always_comb begin
    stepped = edit_bcd;
    stepped[8*cursor +: 8] = step_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      edit_bcd   <= '0;
      blink_cnt  <= '0;
      idle_cnt   <= '0;
      phase      <= 1'b0;
      disp_bcd   <= '0;
      disp_blank <= '0;
      wr_req     <= 1'b0;
      wr_data    <= '0;
      wr_ch      <= 1'b0;
      editing    <= 1'b0;
      cursor     <= '0;
    end else begin
      case (state)
        IDLE: begin
          disp_bcd   <= live_bcd;
          disp_blank <= '0;
          if (key_mode) begin
            state     <= EDIT;
            edit_bcd  <= snap;
            disp_bcd  <= snap;
            cursor    <= CW'(NUM_FIELDS - 1);
            editing   <= 1'b1;
            wr_ch     <= 1'b1;
            blink_cnt <= '0;
            idle_cnt  <= '0;
            phase     <= 1'b0;
          end
        end
        EDIT: begin
          // Any press restarts blink and timeout so the field shows immediately
          if (any_key) begin
            blink_cnt  <= '0;
            idle_cnt   <= '0;
            phase      <= 1'b0;
            disp_blank <= '0;
          end
          if (key_mode) begin
            state   <= COMMIT;
            wr_req  <= 1'b1;
            wr_data <= edit_bcd;
          end else if (key_next) begin
            cursor <= (cursor == '0) ? CW'(NUM_FIELDS - 1) : cursor - CW'(1);
          end else if (key_inc || key_dec) begin
            edit_bcd <= stepped;
            disp_bcd <= stepped;
          end else if (TIMEOUT_CYC != 0 && idle_cnt == TO_LAST) begin
            state      <= IDLE;
            editing    <= 1'b0;
            wr_ch      <= 1'b0;
            disp_blank <= '0;
            disp_bcd   <= live_bcd;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt  <= '0;
              phase      <= ~phase;
              disp_blank <= phase ? '0 : cur_mask;
            end else begin
              blink_cnt <= blink_cnt + 32'd1;
            end
          end
        end
        COMMIT: begin
          if (wr_ack) begin
            state    <= IDLE;
            wr_req   <= 1'b0;
            wr_ch    <= 1'b0;
            editing  <= 1'b0;
            disp_bcd <= live_bcd;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_field_editor.sv
// tb/tb_rtc_field_editor.sv - self-checking bench for rtc_field_editor
// Decimal-arithmetic reference model of the editing rules; directed steps then random keys.
module tb_rtc_field_editor;

  localparam int N    = 3;
  localparam int BDIV = 4;
  localparam int TO   = 50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_mode = 1'b0, key_next = 1'b0, key_inc = 1'b0, key_dec = 1'b0;
  logic          wr_ack = 1'b0;
  logic [23:0]   live_bcd = '0;
  logic [23:0]   disp_bcd, wr_data;
  logic [2:0]    disp_blank;
  logic          wr_req, wr_ch, editing;
  logic [1:0]    cursor;

  int tests = 0;
  int fails = 0;

  rtc_field_editor #(
    .NUM_FIELDS (N),
    .FIELD_MAX  (24'h23_59_59),
    .FIELD_MIN  (24'h00_00_00),
    .BLINK_DIV  (BDIV),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_mode   (key_mode),
    .key_next   (key_next),
    .key_inc    (key_inc),
    .key_dec    (key_dec),
    .live_bcd   (live_bcd),
    .wr_ack     (wr_ack),
    .disp_bcd   (disp_bcd),
    .disp_blank (disp_blank),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .wr_ch      (wr_ch),
    .editing    (editing),
    .cursor     (cursor)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 edit, 2 commit; fields held as decimal integers
  int          m_state;
  int          m_f[3];
  int          m_cur;
  int          m_k;
  logic [23:0] m_idle_disp;
  logic [23:0] m_wdata;
  int          lim_max[3] = '{59, 59, 23};
  int          lim_min[3] = '{0, 0, 0};

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] pack_f();
    return {to_bcd(m_f[2]), to_bcd(m_f[1]), to_bcd(m_f[0])};
  endfunction

  function automatic int sanitize(input logic [7:0] b, input int idx);
    int v;
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return lim_min[idx];
    v = int'(b[7:4]) * 10 + int'(b[3:0]);
    if (v < lim_min[idx] || v > lim_max[idx]) return lim_min[idx];
    return v;
  endfunction

  function automatic logic [23:0] rand_live();
    logic [23:0] r;
    for (int i = 0; i < 3; i++) begin
      if ($urandom_range(0, 7) == 0) r[8*i +: 8] = 8'($urandom_range(0, 255));
      else r[8*i +: 8] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    end
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cur = 0; m_k = 0; m_idle_disp = '0; m_wdata = '0;
    for (int i = 0; i < 3; i++) m_f[i] = 0;
  endtask

  task automatic model_edge(input logic m, input logic n, input logic i, input logic d,
                            input logic a, input logic [23:0] lv);
    case (m_state)
      0: begin
        m_idle_disp = lv;
        if (m) begin
          for (int j = 0; j < 3; j++) m_f[j] = sanitize(lv[8*j +: 8], j);
          m_cur = 2; m_state = 1; m_k = 0;
        end
      end
      1: begin
        if (m) begin
          m_state = 2; m_wdata = pack_f(); m_k = 0;
        end else if (n) begin
          m_cur = (m_cur + 2) % 3; m_k = 0;
        end else if (i) begin
          m_f[m_cur] = (m_f[m_cur] == lim_max[m_cur]) ? lim_min[m_cur] : m_f[m_cur] + 1;
          m_k = 0;
        end else if (d) begin
          m_f[m_cur] = (m_f[m_cur] == lim_min[m_cur]) ? lim_max[m_cur] : m_f[m_cur] - 1;
          m_k = 0;
        end else begin
          m_k++;
          if (m_k == TO) begin
            m_state = 0; m_idle_disp = lv;
          end
        end
      end
      default: begin
        if (a) begin
          m_state = 0; m_idle_disp = lv;
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [2:0] exp_blank;
    exp_blank = (m_state == 1 && ((m_k / BDIV) % 2) == 1) ? (3'b001 << m_cur) : 3'b000;
    chk("disp_bcd", 32'(disp_bcd), 32'((m_state == 0) ? m_idle_disp : pack_f()));
    chk("disp_blank", 32'(disp_blank), 32'(exp_blank));
    chk("wr_req", 32'(wr_req), 32'(m_state == 2));
    chk("wr_data", 32'(wr_data), 32'(m_wdata));
    chk("wr_ch", 32'(wr_ch), 32'(m_state != 0));
    chk("editing", 32'(editing), 32'(m_state != 0));
    chk("cursor", 32'(cursor), 32'(m_cur));
  endtask

  task automatic tick(input logic m, input logic n, input logic i, input logic d,
                      input logic a, input logic [23:0] lv);
    @(negedge clk);
    key_mode = m; key_next = n; key_inc = i; key_dec = d; wr_ack = a; live_bcd = lv;
    @(posedge clk);
    model_edge(m, n, i, d, a, lv);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    key_mode = 0; key_next = 0; key_inc = 0; key_dec = 0; wr_ack = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3 check_all();
    @(negedge clk) rst_n = 1'b1;

    repeat (4) tick(0, 0, 0, 0, 0, rand_live());
    // Ignored keys in IDLE
    tick(0, 1, 1, 1, 1, 24'h01_02_03);

    // Enter edit and commit handshake
    tick(1, 0, 0, 0, 0, 24'h12_34_56);
    chk("enter_cursor", 32'(cursor), 32'd2);
    chk("enter_disp", 32'(disp_bcd), 32'h12_34_56);
    tick(1, 0, 0, 0, 0, 24'h00_00_00);
    repeat (20) tick(0, 1, 1, 0, 0, rand_live());
    chk("commit_hold", 32'(wr_data), 32'h12_34_56);
    tick(0, 0, 0, 0, 1, 24'h11_11_11);
    chk("commit_done", 32'({wr_req, wr_ch, editing}), 32'd0);

    // Increment/decrement wrap and carry
    tick(1, 0, 0, 0, 0, 24'h23_09_56);
    tick(0, 0, 1, 0, 0, 24'h23_09_56);
    chk("inc_wrap", 32'(disp_bcd[23:16]), 32'h00);
    tick(0, 0, 0, 1, 0, 24'h23_09_56);
    chk("dec_wrap", 32'(disp_bcd[23:16]), 32'h23);
    tick(0, 1, 0, 0, 0, 24'h23_09_56);
    tick(0, 0, 1, 0, 0, 24'h23_09_56);
    chk("inc_carry", 32'(disp_bcd[15:8]), 32'h10);
    tick(1, 0, 0, 0, 0, 24'h0);
    tick(0, 0, 0, 0, 1, 24'h0);

    // Sanitise on snapshot and cursor wrap
    tick(1, 0, 0, 0, 0, 24'h12_34_7A);
    chk("sanitise", 32'(disp_bcd[7:0]), 32'h00);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0, 24'h12_34_7A);
    chk("cursor_wrap", 32'(cursor), 32'd2);

    // Blink, key clears blink, then timeout
    repeat (10) tick(0, 0, 0, 0, 0, 24'h12_34_7A);
    tick(0, 0, 1, 0, 0, 24'h12_34_7A);
    chk("blink_clear", 32'(disp_blank), 32'd0);
    repeat (60) tick(0, 0, 0, 0, 1, rand_live());
    chk("timeout", 32'(editing), 32'd0);

    // Simultaneous keys
    tick(1, 0, 0, 0, 0, 24'h10_20_30);
    tick(0, 0, 1, 1, 0, 24'h10_20_30);
    chk("inc_over_dec", 32'(disp_bcd[23:16]), 32'h11);
    tick(1, 0, 1, 0, 0, 24'h10_20_30);
    chk("mode_over_inc", 32'(wr_data), 32'h11_20_30);
    tick(0, 0, 0, 0, 1, 24'h10_20_30);

    // Random keys, acks and live values
    for (int c = 0; c < 400; c++) begin
      tick(($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), rand_live());
    end

    // Reset during COMMIT
    do_reset();
    tick(1, 0, 0, 0, 0, 24'h21_43_05);
    tick(1, 0, 0, 0, 0, 24'h21_43_05);
    repeat (3) tick(0, 0, 0, 0, 0, 24'h21_43_05);
    chk("pre_reset_req", 32'(wr_req), 32'd1);
    do_reset();
    chk("reset_req", 32'(wr_req), 32'd0);
    repeat (3) tick(0, 0, 0, 0, 0, rand_live());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rtc_field_editor.md
Name: rtc_field_editor

Overview:
- Parametrised time/date setting controller between the debounced keys, the 7-segment display driver and the DS1302 register interface.
- Holds N BCD fields. Lets the user snapshot the live RTC value, step a cursor across fields and increment/decrement each field with per-field BCD limits. The cursor field blinks.
- Commits the edited value to the RTC driver through a req/ack handshake.
- Replaces hard-coded hour/minute/second key handling; one instance serves the time (3 fields) and date/year (4 fields) pages.

Parameters:
- NUM_FIELDS, 3, number of 8-bit BCD fields; field 0 = least significant byte.
- FIELD_MAX, 24'h23_59_59, packed BCD upper limit per field (8*NUM_FIELDS bits).
- FIELD_MIN, 24'h00_00_00, packed BCD lower limit per field (8*NUM_FIELDS bits).
- BLINK_DIV, 12_500_000, clk cycles per blink half-period.
- TIMEOUT_CYC, 500_000_000, idle cycles in EDIT before abandoning; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- key_mode  in  1  one-cycle pulse: enter edit / commit
- key_next  in  1  one-cycle pulse: move cursor
- key_inc  in  1  one-cycle pulse: increment field
- key_dec  in  1  one-cycle pulse: decrement field
- live_bcd  in  8*NUM_FIELDS  current RTC value
- wr_ack  in  1  RTC driver write complete (one-cycle pulse)
- disp_bcd  out  8*NUM_FIELDS  value to display
- disp_blank  out  NUM_FIELDS  1 = blank that field this cycle
- wr_req  out  1  write request, held until wr_ack
- wr_data  out  8*NUM_FIELDS  value to write, stable while wr_req=1
- wr_ch  out  1  clock-halt flag to the RTC driver, high in EDIT and COMMIT
- editing  out  1  high in EDIT and COMMIT
- cursor  out  $clog2(NUM_FIELDS) (min 1)  selected field index

Behaviour:
- Reset value of every output: disp_bcd=0, disp_blank=0, wr_req=0, wr_data=0, wr_ch=0, editing=0, cursor=0.
- Reset state: IDLE. Edit registers, blink counter and timeout counter reset to 0.
- All outputs are registered. Response appears 1 cycle after the key pulse.
- IDLE:
  - disp_bcd follows live_bcd (1-cycle register delay); disp_blank=0.
  - key_mode: snapshot live_bcd into the edit registers, then go to EDIT with cursor=NUM_FIELDS-1.
  - During the snapshot, any field that is invalid BCD (nibble>9) or outside [MIN,MAX] is loaded as its MIN.
  - Other keys are ignored.
- EDIT:
  - disp_bcd = edit registers.
  - Key priority on the same cycle: mode > next > inc > dec. Only one action per cycle.
  - key_next: cursor-1; from 0 it wraps to NUM_FIELDS-1.
  - key_inc: BCD +1 on the cursor field. Ones 9 rolls to 0 and carries into tens. Value==MAX wraps to MIN.
  - key_dec: BCD -1 on the cursor field. Ones 0 becomes 9 and borrows from tens. Value==MIN wraps to MAX.
  - key_mode: go to COMMIT.
  - Timeout: the counter counts cycles with no key. At TIMEOUT_CYC, go to IDLE, discard the edit, wr_ch=0, no write.
- COMMIT:
  - wr_req=1, wr_data = edit registers; hold both until wr_ack.
  - On wr_ack, go to IDLE; wr_req and wr_ch fall on the next cycle.
  - All keys are ignored. No timeout applies in COMMIT.
  - wr_ack outside COMMIT is ignored.
- Blink:
  - The counter counts to BLINK_DIV-1 and then toggles phase.
  - In EDIT, disp_blank[cursor]=phase; all other bits are 0.
  - Counter and phase clear on entering EDIT and on any accepted key, so the field is visible right after a press.
  - In COMMIT and IDLE, disp_blank=0.
- Reset mid-COMMIT: wr_req drops asynchronously and the edit is lost. The RTC driver must treat a dropped req as an abort.
- Per-field limits are compared as 8-bit BCD values; MIN<=MAX is a legal-parameter requirement and is checked by an elaboration assertion.

Decomposition:
- Shared package rtc_pkg:
  - state enum {IDLE, EDIT, COMMIT}
  - BCD_W=8
  - default limit vectors: TIME_MAX=24'h23_59_59, DATE_MAX=32'h99_12_31_07 (year, month, date, week), DATE_MIN=32'h00_01_01_01
- Sub-module bcd_field_step: combinational. Inputs value, min, max, inc, dec; output next value with BCD carry/borrow and wrap.
  - Instantiated once, muxed by cursor.

Test Plan:
- Enter edit: live_bcd=24'h12_34_56, pulse key_mode → 1 cycle later editing=1, wr_ch=1, cursor=2, disp_bcd=24'h12_34_56.
- Inc wrap: from 23_xx_xx on field 2, one key_inc → field 2=8'h00. key_dec on 00 → 8'h23. Field 1 at 8'h09 + inc → 8'h10.
- Cursor and sanitise: live field 0=8'h7A, enter edit → field 0 loads 8'h00. key_next ×3 yields cursor 1,0,2.
- Commit handshake: key_mode in EDIT → wr_req=1, wr_data stable for 20 cycles. Pulse wr_ack → wr_req=0, wr_ch=0, editing=0 next cycle.
- Blink/timeout (BLINK_DIV=4, TIMEOUT_CYC=50): disp_blank[2] toggles every 4 cycles; a key clears it to 0. No keys for 50 cycles → IDLE with wr_req never asserted.
- Simultaneous key_inc and key_dec → only +1 applied. key_mode and key_inc together in EDIT → COMMIT with the field unchanged. Reset asserted mid-COMMIT → all outputs 0 immediately.
